// File: rtl/ksw_loop2_pkg.sv
// Shared types and defaults for the ksw loop_2 row sequencer.
package ksw_loop2_pkg;

    localparam int TW_DEF   = 10;   // vector index width
    localparam int NVEC_DEF = 126;  // vector entries per row

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // One in-flight loop_2 index. The index field is TW_DEF wide, so the
    // sequencer's TW must not exceed TW_DEF.
    typedef struct packed {
        logic              vld;
        logic [TW_DEF-1:0] idx;
    } pipe_ent_t;

endpackage

// File: rtl/ksw_loop2_pipe.sv
// LAT-deep {valid,index} delay line mirroring the loop_2 datapath latency.
// The whole line freezes while stall is high.
module ksw_loop2_pipe
    import ksw_loop2_pkg::*;
#(
    parameter int TW  = TW_DEF,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          in_vld,
    input  logic [TW-1:0] in_idx,
    output logic          out_vld,
    output logic [TW-1:0] out_idx,
    output logic          inner_vld   // any valid entry behind the tail
);

    pipe_ent_t [LAT-1:0] stg;
    pipe_ent_t           head;

    // Pack the issued index into a pipeline entry.
    always_comb begin
        head.vld = in_vld;
        head.idx = TW_DEF'(in_idx);
    end

    // Shift one stage per non-stalled cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else if (!stall) begin
            stg[0] <= head;
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
    end

    // Lets the sequencer see when the tail holds the last in-flight result.
    always_comb begin
        inner_vld = 1'b0;
        for (int i = 0; i < LAT - 1; i++) inner_vld = inner_vld | stg[i].vld;
    end

    assign out_vld = stg[LAT-1].vld;
    assign out_idx = TW'(stg[LAT-1].idx);

endmodule

// File: rtl/ksw_loop2_seq.sv
// Row sequencer for ksw loop_2: walks t from r_st to r_en, tracks results
// through a LAT-cycle pipeline and strobes write-back in issue order.
// Optional build macro KSW_LOOP2_PERF_EN enables the busy/stall perf counters;
// without it perf_busy/perf_stall are tied to zero.
module ksw_loop2_seq
    import ksw_loop2_pkg::*;
#(
    parameter int TW   = TW_DEF,
    parameter int NVEC = NVEC_DEF,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [TW-1:0] r_st,
    input  logic [TW-1:0] r_en,
    input  logic          stall,
    output logic          busy,
    output logic [TW-1:0] t,
    output logic          rd_en,
    output logic          carry_ld,
    output logic          wr_en,
    output logic [TW-1:0] wr_t,
    output logic          done,
    output logic          err,
    output logic [15:0]   perf_busy,
    output logic [15:0]   perf_stall
);

    localparam logic [TW:0] NVEC_W = (TW+1)'(NVEC);

    state_t        state;
    logic [TW-1:0] st_q;
    logic [TW-1:0] en_q;
    logic          row_ok;
    logic          accept;
    logic          tail_vld;
    logic          inner_vld;
    logic [TW-1:0] tail_idx;

    assign row_ok   = (r_st <= r_en) && ({1'b0, r_en} < NVEC_W);
    assign accept   = (state == S_IDLE) && start && row_ok;
    assign busy     = (state != S_IDLE);
    // Issue and write-back react to stall in the same cycle.
    assign rd_en    = (state == S_ISSUE) && !stall;
    // t only climbs, so t==r_st marks the first issue even across stalls.
    assign carry_ld = rd_en && (t == st_q);
    assign wr_en    = tail_vld && !stall;
    assign wr_t     = tail_idx;

    // Row FSM: accept/reject in IDLE, walk t in ISSUE, wait for the tail in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            t     <= '0;
            st_q  <= '0;
            en_q  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (row_ok) begin
                            st_q  <= r_st;
                            en_q  <= r_en;
                            t     <= r_st;
                            state <= S_ISSUE;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        // Hold t at r_en on the last issue: no wrap past the row.
                        if (t == en_q) state <= S_DRAIN;
                        else           t     <= t + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!stall && tail_vld && !inner_vld) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ksw_loop2_pipe #(
        .TW  (TW),
        .LAT (LAT)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .in_vld    (rd_en),
        .in_idx    (t),
        .out_vld   (tail_vld),
        .out_idx   (tail_idx),
        .inner_vld (inner_vld)
    );

`ifdef KSW_LOOP2_PERF_EN
    // Saturating busy/stall cycle counters, restarted by each accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (accept) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (busy) begin
            if (perf_busy != 16'hFFFF)           perf_busy  <= perf_busy + 16'd1;
            if (stall && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
        end
    end
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ksw_loop2_seq.sv
// Directed bench for ksw_loop2_seq (LAT=2, NVEC=126). Each cyc() call checks
// one clock cycle: inputs are set just after the rising edge, outputs are
// checked 1 time unit later.
module tb_ksw_loop2_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  r_st;
    logic [9:0]  r_en;
    logic        stall;
    logic        busy;
    logic [9:0]  t;
    logic        rd_en;
    logic        carry_ld;
    logic        wr_en;
    logic [9:0]  wr_t;
    logic        done;
    logic        err;
    logic [15:0] perf_busy;
    logic [15:0] perf_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ksw_loop2_seq #(.TW(10), .NVEC(126), .LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .r_st       (r_st),
        .r_en       (r_en),
        .stall      (stall),
        .busy       (busy),
        .t          (t),
        .rd_en      (rd_en),
        .carry_ld   (carry_ld),
        .wr_en      (wr_en),
        .wr_t       (wr_t),
        .done       (done),
        .err        (err),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Check one cycle, then advance to just after the next rising edge.
    // et / ewt < 0 means t / wr_t are not checked this cycle.
    task automatic cyc(input string tag, input logic b, input logic rd, input logic cl,
                       input logic wr, input logic d, input logic e,
                       input int et, input int ewt);
        #1;
        chk({tag, ".busy"},     32'(busy),     32'(b));
        chk({tag, ".rd_en"},    32'(rd_en),    32'(rd));
        chk({tag, ".carry_ld"}, 32'(carry_ld), 32'(cl));
        chk({tag, ".wr_en"},    32'(wr_en),    32'(wr));
        chk({tag, ".done"},     32'(done),     32'(d));
        chk({tag, ".err"},      32'(err),      32'(e));
        if (et >= 0)  chk({tag, ".t"},    32'(t),    32'(et));
        if (ewt >= 0) chk({tag, ".wr_t"}, 32'(wr_t), 32'(ewt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        r_st  = '0;
        r_en  = '0;
        stall = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cyc("rst0", 0,0,0,0,0,0, 0,0);
        cyc("rst1", 0,0,0,0,0,0, 0,0);
        chk("rst.perf_busy",  32'(perf_busy),  32'd0);
        chk("rst.perf_stall", 32'(perf_stall), 32'd0);
        rst_n = 1'b1;
        cyc("idle", 0,0,0,0,0,0, 0,0);

        // Row 0..3, no stall
        start = 1'b1; r_st = 10'd0; r_en = 10'd3;
        cyc("a0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("a1", 1,1,1,0,0,0, 0,-1);
        cyc("a2", 1,1,0,0,0,0, 1,-1);
        cyc("a3", 1,1,0,1,0,0, 2,0);
        cyc("a4", 1,1,0,1,0,0, 3,1);
        cyc("a5", 1,0,0,1,0,0, 3,2);
        cyc("a6", 1,0,0,1,0,0, -1,3);
        cyc("a7", 0,0,0,0,1,0, -1,-1);
        cyc("a8", 0,0,0,0,0,0, -1,-1);

        // Same row, stall in cycles 2-3
        start = 1'b1; r_st = 10'd0; r_en = 10'd3;
        cyc("b0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("b1", 1,1,1,0,0,0, 0,-1);
        stall = 1'b1;
        cyc("b2", 1,0,0,0,0,0, 1,-1);
        cyc("b3", 1,0,0,0,0,0, 1,-1);
        stall = 1'b0;
        cyc("b4", 1,1,0,0,0,0, 1,-1);
        cyc("b5", 1,1,0,1,0,0, 2,0);
        cyc("b6", 1,1,0,1,0,0, 3,1);
        cyc("b7", 1,0,0,1,0,0, -1,2);
        cyc("b8", 1,0,0,1,0,0, -1,3);
`ifdef KSW_LOOP2_PERF_EN
        chk("b.perf_busy",  32'(perf_busy),  32'd8);
        chk("b.perf_stall", 32'(perf_stall), 32'd2);
`else
        chk("b.perf_busy",  32'(perf_busy),  32'd0);
        chk("b.perf_stall", 32'(perf_stall), 32'd0);
`endif
        cyc("b9", 0,0,0,0,1,0, -1,-1);

        // Rejected rows: r_st > r_en, then r_en out of range
        start = 1'b1; r_st = 10'd5; r_en = 10'd2;
        cyc("c0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("c1", 0,0,0,0,1,1, -1,-1);
        start = 1'b1; r_st = 10'd0; r_en = 10'd126;
        cyc("c2", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("c3", 0,0,0,0,1,1, -1,-1);
        cyc("c4", 0,0,0,0,0,0, -1,-1);

        // Single-index row at the top of the range
        start = 1'b1; r_st = 10'd125; r_en = 10'd125;
        cyc("d0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("d1", 1,1,1,0,0,0, 125,-1);
        cyc("d2", 1,0,0,0,0,0, 125,-1);
        cyc("d3", 1,0,0,1,0,0, -1,125);
        cyc("d4", 0,0,0,0,1,0, -1,-1);

        // Stall while a result sits at the pipeline tail
        start = 1'b1; r_st = 10'd0; r_en = 10'd1;
        cyc("e0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("e1", 1,1,1,0,0,0, 0,-1);
        cyc("e2", 1,1,0,0,0,0, 1,-1);
        stall = 1'b1;
        cyc("e3", 1,0,0,0,0,0, -1,-1);
        stall = 1'b0;
        cyc("e4", 1,0,0,1,0,0, -1,0);
        cyc("e5", 1,0,0,1,0,0, -1,1);
        cyc("e6", 0,0,0,0,1,0, -1,-1);

        // Start while busy is ignored; reset mid-row flushes everything
        start = 1'b1; r_st = 10'd0; r_en = 10'd3;
        cyc("f0", 0,0,0,0,0,0, -1,-1);
        r_st = 10'd7; r_en = 10'd9;
        cyc("f1", 1,1,1,0,0,0, 0,-1);
        start = 1'b0;
        cyc("f2", 1,1,0,0,0,0, 1,-1);
        rst_n = 1'b0;
        cyc("f3", 0,0,0,0,0,0, 0,0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc($sformatf("f%0d", 4 + i), 0,0,0,0,0,0, 0,0);

        // Fresh row after reset still works
        start = 1'b1; r_st = 10'd2; r_en = 10'd2;
        cyc("g0", 0,0,0,0,0,0, -1,-1);
        start = 1'b0;
        cyc("g1", 1,1,1,0,0,0, 2,-1);
        cyc("g2", 1,0,0,0,0,0, 2,-1);
        cyc("g3", 1,0,0,1,0,0, -1,2);
        cyc("g4", 0,0,0,0,1,0, -1,-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksw_loop2_seq.md
KSW_LOOP2_SEQ -- requirements
Module: ksw_loop2_seq

Interface
REQ-001 SHALL have parameter TW, default 10, width of the vector index t.
REQ-002 SHALL have parameter NVEC, default 126, number of 128-bit vector entries per row (u,v,x,y,x2,y2,s).
REQ-003 SHALL have parameter LAT, default 2 (legal 1..8), loop_2 datapath latency in cycles from index issue to result.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to process one row.
REQ-007 r_st  in  TW  first vector index of the row; sampled with start.
REQ-008 r_en  in  TW  last vector index of the row, inclusive; sampled with start.
REQ-009 stall  in  1  vector-memory backpressure; freezes issue and pipeline.
REQ-010 busy  out  1  high while state is not IDLE.
REQ-011 t  out  TW  index presented to loop_2 and the vector memories.
REQ-012 rd_en  out  1  read u,v,x,y,x2,y2,s at t this cycle.
REQ-013 carry_ld  out  1  load x1_/x21_/v1_ carry-ins; high only with the first rd_en of a row.
REQ-014 wr_en  out  1  write-back strobe for loop_2 results.
REQ-015 wr_t  out  TW  index being written back.
REQ-016 done  out  1  one-cycle row-complete pulse.
REQ-017 err  out  1  one-cycle pulse, coincident with done, for a rejected row.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-019 IDLE: start with r_st<=r_en<NVEC SHALL latch both values and enter ISSUE next cycle with t=r_st.
REQ-020 IDLE: start with r_st>r_en or r_en>=NVEC SHALL issue nothing and pulse done and err the next cycle.
REQ-021 ISSUE: rd_en=!stall; t SHALL increment by 1 on each non-stalled cycle; on the non-stalled cycle with t==r_en the FSM SHALL enter DRAIN.
REQ-022 An index issued in non-stalled cycle k SHALL appear on wr_en/wr_t in cycle k+LAT plus the number of stalled cycles in between; results stay in issue order.
REQ-023 wr_en SHALL be 0 whenever stall=1; the pipeline SHALL hold its contents while stalled.
REQ-024 DRAIN: the FSM SHALL return to IDLE and pulse done in the cycle after the last wr_en.
REQ-025 start while busy SHALL be ignored; there is no queueing.
REQ-026 t, wr_t SHALL never exceed NVEC-1; there is no wrap-around.
REQ-027 A single-index row (r_st==r_en) SHALL assert rd_en and carry_ld together for one cycle.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear the pipeline, and drive busy=rd_en=carry_ld=wr_en=done=err=0, t=wr_t=0.
REQ-029 Reset mid-row SHALL discard all in-flight indices; no wr_en is produced after release until a new start.

Configuration
REQ-030 With macro KSW_LOOP2_PERF_EN defined, output perf_busy (16 bits, saturating) SHALL count busy cycles and perf_stall (16 bits, saturating) SHALL count stalled busy cycles; both clear on reset and on each accepted start.
REQ-031 Without KSW_LOOP2_PERF_EN, perf_busy and perf_stall SHALL exist and be tied to 0, with no counter logic.

Structure
REQ-032 Package ksw_loop2_pkg SHALL hold the FSM state enum, TW and NVEC defaults, and a {valid,index} pipeline-entry typedef.
REQ-033 The LAT-deep {valid,index} shift register with stall hold SHALL be the sub-module ksw_loop2_pipe.

Verification
REQ-034 LAT=2, start with r_st=0, r_en=3, no stall -> rd_en in cycles 1-4 with t=0..3, carry_ld in cycle 1 only, wr_en in cycles 3-6 with wr_t=0..3, done in cycle 7.
REQ-035 Same row with stall=1 in cycles 2-3 -> t holds at 1, rd_en=0 and wr_en=0 in cycles 2-3, wr_t sequence 0..3 intact, done in cycle 9.
REQ-036 start with r_st=5, r_en=2, then r_st=0, r_en=126 -> no rd_en, done and err pulse in the cycle after each start.
REQ-037 r_st=r_en=125 -> one rd_en with carry_ld at t=125, one wr_en at wr_t=125, done in cycle LAT+2.
REQ-038 rst_n low in cycle 3 of the REQ-034 row, then released -> all outputs 0, no wr_en until the next start; a second start during busy is ignored.
REQ-039 With KSW_LOOP2_PERF_EN, the REQ-035 row -> perf_busy=8, perf_stall=2.
